// File: rtl/multicycle_ctrl_if.sv
// multicycle_ctrl_if: instruction/flag inputs and control outputs between multicycle_ctrl and the datapath
interface multicycle_ctrl_if;
  logic [31:0] instr;
  logic        Zero;
  logic [2:0]  state;
  logic [3:0]  ALUCtrl;
  logic        ALUSrc;
  logic        MemToReg;
  logic        RegWrite;
  logic        MemRead;
  logic        MemWrite;
  logic        loadPC;
  logic        PCSrc;
  modport master (
    input  instr, Zero,
    output state, ALUCtrl, ALUSrc, MemToReg, RegWrite, MemRead, MemWrite, loadPC, PCSrc
  );
  modport slave (
    output instr, Zero,
    input  state, ALUCtrl, ALUSrc, MemToReg, RegWrite, MemRead, MemWrite, loadPC, PCSrc
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: IF/ID/EX/MEM/WB sequencer and decoder for the multicycle RV32I core.
// Define MULTICYCLE_MEM_SKIP_EN to route EX straight to WB for non-memory opcodes.
module multicycle_ctrl (
  input logic               clk,
  input logic               rst,
  multicycle_ctrl_if.master bus
);
  typedef enum logic [2:0] {S_IF = 3'd0, S_ID = 3'd1, S_EX = 3'd2, S_MEM = 3'd3, S_WB = 3'd4} state_t;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_SRL = 4'b1000;
  localparam logic [3:0] ALU_SLL = 4'b1001;
  localparam logic [3:0] ALU_SRA = 4'b1010;
  localparam logic [3:0] ALU_XOR = 4'b0101;
  logic [2:0] state_q;
  state_t     next_state;
  logic       zero_q;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7_5;
  logic       is_r, is_i, is_lw, is_sw, is_beq;
  logic [3:0] alu;
  logic       unused_bits;
  assign opcode      = bus.instr[6:0];
  assign funct3      = bus.instr[14:12];
  assign funct7_5    = bus.instr[30];
  assign unused_bits = ^{bus.instr[31], bus.instr[29:15], bus.instr[11:7]};
  assign is_r   = opcode == OP_R;
  assign is_i   = opcode == OP_I;
  assign is_lw  = opcode == OP_LW;
  assign is_sw  = opcode == OP_SW;
  assign is_beq = opcode == OP_BEQ;
  always_comb begin
    next_state = S_IF;
    case (state_q)
      S_IF:  next_state = S_ID;
      S_ID:  next_state = S_EX;
`ifdef MULTICYCLE_MEM_SKIP_EN
      S_EX:  next_state = (is_lw | is_sw) ? S_MEM : S_WB;
`else
      S_EX:  next_state = S_MEM;
`endif
      S_MEM: next_state = S_WB;
      default: next_state = S_IF;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= S_IF;
      zero_q  <= 1'b0;
    end else begin
      state_q <= next_state;
      if (state_q == S_EX) zero_q <= bus.Zero;
    end
  // funct7[5] selects SUB only for R-type; immediates reuse that bit, so I-ALU ignores it except for shifts
  always_comb begin
    alu = ALU_ADD;
    if (is_beq) alu = ALU_SUB;
    else if (is_r | is_i)
      case (funct3)
        3'b000:  alu = (is_r & funct7_5) ? ALU_SUB : ALU_ADD;
        3'b111:  alu = ALU_AND;
        3'b110:  alu = ALU_OR;
        3'b100:  alu = ALU_XOR;
        3'b010:  alu = ALU_SLT;
        3'b001:  alu = ALU_SLL;
        3'b101:  alu = funct7_5 ? ALU_SRA : ALU_SRL;
        default: alu = ALU_ADD;
      endcase
  end
  assign bus.state    = state_q;
  assign bus.ALUCtrl  = alu;
  assign bus.ALUSrc   = is_i | is_lw | is_sw;
  assign bus.MemToReg = is_lw;
  assign bus.MemRead  = (state_q == S_MEM) & is_lw;
  assign bus.MemWrite = (state_q == S_MEM) & is_sw;
  assign bus.RegWrite = (state_q == S_WB) & (is_r | is_i | is_lw);
  assign bus.loadPC   = state_q == S_WB;
  assign bus.PCSrc    = (state_q == S_WB) & is_beq & zero_q;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: scoreboard bench; a per-instruction cycle trace model feeds a queue checked by a negedge monitor
module tb_multicycle_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  multicycle_ctrl_if bus ();
  multicycle_ctrl dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {
    logic [31:0] ins;
    logic [13:0] v;
  } exp_t;
  exp_t exp_q[$];
  exp_t e;
  int n_checks = 0;
  int n_fail = 0;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic logic [3:0] exp_alu(input logic [31:0] ins);
    logic [6:0] op = ins[6:0];
    logic [2:0] f3 = ins[14:12];
    logic f7 = ins[30];
    if (op == 7'b0000011 || op == 7'b0100011) return 4'b0010;
    if (op == 7'b1100011) return 4'b0110;
    if (op != 7'b0110011 && op != 7'b0010011) return 4'b0010;
    if (f3 == 3'b000) return (op == 7'b0110011 && f7) ? 4'b0110 : 4'b0010;
    if (f3 == 3'b111) return 4'b0000;
    if (f3 == 3'b110) return 4'b0001;
    if (f3 == 3'b100) return 4'b0101;
    if (f3 == 3'b010) return 4'b0111;
    if (f3 == 3'b001) return 4'b1001;
    if (f3 == 3'b101) return f7 ? 4'b1010 : 4'b1000;
    return 4'b0010;
  endfunction
  // Called at posedge+1 with the DUT in IF; leaves at posedge+1 of the next IF
  task automatic run_instr(input logic [31:0] ins, input logic z_ex);
    logic [6:0] op = ins[6:0];
    logic lw = op == 7'b0000011;
    logic sw = op == 7'b0100011;
    logic beq = op == 7'b1100011;
    logic wr = op == 7'b0110011 || op == 7'b0010011 || lw;
    logic skip_mem = 1'b0;
    exp_t x;
`ifdef MULTICYCLE_MEM_SKIP_EN
    skip_mem = !(lw || sw);
`endif
    for (int s = 0; s < 5; s++) begin
      if (s == 3 && skip_mem) continue;
      bus.instr = ins;
      bus.Zero  = (s == 2) ? z_ex : ~z_ex;
      x.ins = ins;
      x.v = {3'(s), exp_alu(ins), lw || sw || op == 7'b0010011, lw,
             s == 4 && wr, s == 3 && lw, s == 3 && sw, s == 4, s == 4 && beq && z_ex};
      exp_q.push_back(x);
      @(posedge clk);
      #1;
    end
  endtask
  function automatic logic [31:0] rand_instr();
    logic [31:0] r = $urandom;
    case ($urandom_range(0, 5))
      0: r[6:0] = 7'b0110011;
      1: r[6:0] = 7'b0010011;
      2: r[6:0] = 7'b0000011;
      3: r[6:0] = 7'b0100011;
      4: r[6:0] = 7'b1100011;
      default: ;
    endcase
    return r;
  endfunction
  always @(negedge clk)
    if (!rst && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if ({bus.state, bus.ALUCtrl, bus.ALUSrc, bus.MemToReg, bus.RegWrite, bus.MemRead,
           bus.MemWrite, bus.loadPC, bus.PCSrc} !== e.v) begin
        n_fail++;
        $display("FAIL cycle instr=%08h: got st/alu/src/m2r/rw/mr/mw/lpc/pcs=%b expected %b", e.ins,
                 {bus.state, bus.ALUCtrl, bus.ALUSrc, bus.MemToReg, bus.RegWrite, bus.MemRead,
                  bus.MemWrite, bus.loadPC, bus.PCSrc}, e.v);
      end
    end
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    bus.instr = 32'h002081B3;
    bus.Zero  = 1'b0;
    #2;
    check("reset_state", bus.state, 0);
    check("reset_strobes", {bus.RegWrite, bus.MemRead, bus.MemWrite, bus.loadPC, bus.PCSrc}, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    run_instr(32'h002081B3, 1'b1);
    run_instr(32'h402081B3, 1'b0);
    run_instr(32'h4020D193, 1'b1);
    run_instr(32'h0080A283, 1'b0);
    run_instr(32'h0050A223, 1'b1);
    run_instr(32'h00208463, 1'b1);
    run_instr(32'h00208463, 1'b0);
    bus.instr = 32'h00208463;
    bus.Zero  = 1'b1;
`ifdef MULTICYCLE_MEM_SKIP_EN
    repeat (3) @(posedge clk);
`else
    repeat (4) @(posedge clk);
`endif
    #1;
    check("wb_before_reset", {bus.state, bus.loadPC, bus.PCSrc}, {3'd4, 2'b11});
    #2 rst = 1'b1;
    #1;
    check("async_reset_state", bus.state, 0);
    check("async_reset_strobes", {bus.RegWrite, bus.MemRead, bus.MemWrite, bus.loadPC, bus.PCSrc}, 0);
    @(posedge clk);
    #1;
    check("held_reset", {bus.state, bus.RegWrite, bus.loadPC}, 0);
    rst = 1'b0;
    repeat (150) run_instr(rand_instr(), 1'($urandom_range(0, 1)));
    bus.instr = 32'h0080A283;
    force dut.state_q = 3'd6;
    #1;
    check("illegal_next", dut.next_state, 0);
    check("illegal_strobes", {bus.RegWrite, bus.MemRead, bus.MemWrite, bus.loadPC, bus.PCSrc}, 0);
    release dut.state_q;
    rst = 1'b1;
    #1;
    check("illegal_reset_state", bus.state, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    run_instr(32'h0080A283, 1'b0);
    @(negedge clk);
    check("queue_drain", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
